// File: rtl/mod_counter.sv
// mod_counter: loadable up/down counter over the range 0..limit with a
// programmable step, selectable saturate-or-wrap behaviour at the bounds,
// a one-cycle terminal pulse and a sticky overflow flag.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   clr        synchronous clear of count, tc and ovf (highest priority)
//   load       synchronous load of min(data_in, limit)
//   en         count enable
//   up_down    1 = count up, 0 = count down
//   sat        1 = saturate at the bounds, 0 = wrap modulo (limit+1)
//   step       magnitude added/subtracted per enabled cycle
//   limit      inclusive upper bound of the count
//   data_in    load value
//   data_out   current count (registered)
//   end_count  high while data_out == 0
//   at_limit   high while data_out == limit
//   tc         registered one-cycle pulse after every bound event
//   ovf        registered sticky flag, set by any bound event
module mod_counter #(
    parameter int N      = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic              en,
    input  logic              up_down,
    input  logic              sat,
    input  logic [STEP_W-1:0] step,
    input  logic [N-1:0]      limit,
    input  logic [N-1:0]      data_in,
    output logic [N-1:0]      data_out,
    output logic              end_count,
    output logic              at_limit,
    output logic              tc,
    output logic              ovf
);

    localparam logic [N:0]   ONE_X = (N+1)'(1);
    localparam logic [N-1:0] ONE_N = N'(1);

    // Widened copies so that sums and comparisons never overflow.
    logic [N:0]   cnt_x;
    logic [N:0]   lim_x;
    logic [N:0]   step_x;
    logic [N:0]   sum_x;
    logic [N:0]   wrap_up_x;
    logic [N:0]   dn_base_x;
    logic [N-1:0] step_n;
    logic [N-1:0] diff_n;
    logic [N-1:0] wrap_dn_n;
    logic [N-1:0] next_cnt;
    logic         bound;

    assign cnt_x     = {1'b0, data_out};
    assign lim_x     = {1'b0, limit};
    assign step_x    = {{(N+1-STEP_W){1'b0}}, step};
    assign step_n    = {{(N-STEP_W){1'b0}}, step};
    assign sum_x     = cnt_x + step_x;
    assign wrap_up_x = sum_x - lim_x - ONE_X;
    assign dn_base_x = cnt_x + lim_x + ONE_X;
    assign diff_n    = data_out - step_n;
    // Only used when dn_base_x >= step_x, where the true result is <= limit
    // and therefore exact in N bits.
    assign wrap_dn_n = data_out + limit + ONE_N - step_n;

    always_comb begin
        next_cnt = data_out;
        bound    = 1'b0;
        if (cnt_x > lim_x) begin
            // Count left stranded above a lowered limit.
            bound    = 1'b1;
            next_cnt = sat ? limit : '0;
        end else if (up_down) begin
            if (sum_x <= lim_x) begin
                next_cnt = sum_x[N-1:0];
            end else begin
                bound = 1'b1;
                if (sat)
                    next_cnt = limit;
                else if (wrap_up_x > lim_x)
                    next_cnt = '0;
                else
                    next_cnt = wrap_up_x[N-1:0];
            end
        end else begin
            if (step_x <= cnt_x) begin
                next_cnt = diff_n;
            end else begin
                bound = 1'b1;
                if (sat)
                    next_cnt = '0;
                else if (dn_base_x < step_x)
                    next_cnt = limit;
                else
                    next_cnt = wrap_dn_n;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            tc       <= 1'b0;
            ovf      <= 1'b0;
        end else if (clr) begin
            data_out <= '0;
            tc       <= 1'b0;
            ovf      <= 1'b0;
        end else if (load) begin
            data_out <= (data_in > limit) ? limit : data_in;
            tc       <= 1'b0;
            ovf      <= 1'b0;
        end else if (en && (step != '0)) begin
            data_out <= next_cnt;
            tc       <= bound;
            if (bound)
                ovf <= 1'b1;
        end else begin
            // Hold, including an enabled zero step.
            tc <= 1'b0;
        end
    end

    assign end_count = (data_out == '0);
    assign at_limit  = (data_out == limit);

endmodule

// File: tb/tb_mod_counter.sv
module tb_mod_counter;
    localparam int N  = 8;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          load = 1'b0;
    logic          en = 1'b0;
    logic          up_down = 1'b0;
    logic          sat = 1'b0;
    logic [SW-1:0] step = '0;
    logic [N-1:0]  limit = '0;
    logic [N-1:0]  data_in = '0;
    logic [N-1:0]  data_out;
    logic          end_count;
    logic          at_limit;
    logic          tc;
    logic          ovf;

    mod_counter #(.N(N), .STEP_W(SW)) dut (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .en(en),
        .up_down(up_down), .sat(sat), .step(step), .limit(limit),
        .data_in(data_in), .data_out(data_out), .end_count(end_count),
        .at_limit(at_limit), .tc(tc), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int lim;
        bit tc;
        bit ovf;
    } exp_t;

    exp_t sbq[$];
    int   m_cnt = 0;
    bit   m_ovf = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cur_lim = 100;

    task automatic check(input string name, input logic [31:0] act, input int req);
        n_checks++;
        if (act !== 32'(req)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: the counting rules written directly as integer arithmetic.
    task automatic drive(input bit c, input bit l, input bit e, input bit ud,
                         input bit s, input int st, input int lim, input int din);
        exp_t x;
        bit   ev;
        int   w;
        @(negedge clk);
        clr = c; load = l; en = e; up_down = ud; sat = s;
        step = SW'(st); limit = N'(lim); data_in = N'(din);
        ev = 1'b0;
        if (c) begin
            m_cnt = 0; m_ovf = 1'b0;
        end else if (l) begin
            m_cnt = (din < lim) ? din : lim; m_ovf = 1'b0;
        end else if (e && st != 0) begin
            if (m_cnt > lim) begin
                ev = 1'b1; m_cnt = s ? lim : 0;
            end else if (ud) begin
                if (m_cnt + st <= lim) m_cnt = m_cnt + st;
                else begin
                    ev = 1'b1;
                    w  = m_cnt + st - (lim + 1);
                    m_cnt = s ? lim : ((w > lim) ? 0 : w);
                end
            end else begin
                if (st <= m_cnt) m_cnt = m_cnt - st;
                else begin
                    ev = 1'b1;
                    w  = m_cnt + lim + 1 - st;
                    m_cnt = s ? 0 : ((w < 0) ? lim : w);
                end
            end
            if (ev) m_ovf = 1'b1;
        end
        x.cnt = m_cnt; x.lim = lim; x.tc = ev; x.ovf = m_ovf;
        sbq.push_back(x);
    endtask

    // Monitor: compares the DUT against the oldest pending expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                check("data_out", 32'(data_out), x.cnt);
                check("tc", 32'(tc), int'(x.tc));
                check("ovf", 32'(ovf), int'(x.ovf));
                check("end_count", 32'(end_count), (x.cnt == 0) ? 1 : 0);
                check("at_limit", 32'(at_limit), (x.cnt == x.lim) ? 1 : 0);
            end
        end
    end

    initial begin
        int  wait_cyc;
        bit  c, l, e;
        int  r;

        // Reset state, checked asynchronously.
        #2;
        check("rst_data_out", 32'(data_out), 0);
        check("rst_tc", 32'(tc), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_end_count", 32'(end_count), 1);
        check("rst_at_limit_lim0", 32'(at_limit), 1);
        limit = N'(5);
        #1;
        check("rst_at_limit_lim5", 32'(at_limit), 0);
        #9 rst = 1'b0;

        // Wrap past limit 9, then a normal step.
        drive(0, 1, 0, 1, 0, 3, 9, 8);
        drive(0, 0, 1, 1, 0, 3, 9, 0);
        drive(0, 0, 1, 1, 0, 3, 9, 0);
        // clr beats load and en, clears ovf.
        drive(1, 1, 1, 1, 0, 3, 9, 7);
        // Saturating down count at zero, repeated bound events.
        drive(0, 1, 0, 0, 1, 4, 200, 5);
        repeat (3) drive(0, 0, 1, 0, 1, 4, 200, 0);
        // Load clamped to limit.
        drive(0, 1, 0, 0, 0, 0, 50, 100);
        // Zero step holds with no event.
        drive(0, 1, 0, 1, 0, 0, 100, 12);
        repeat (5) drive(0, 0, 1, 1, 0, 0, 100, 0);
        // Limit zero: every non-zero step is a bound event.
        drive(0, 0, 1, 1, 0, 3, 0, 0);
        drive(0, 0, 1, 0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0, 2, 0, 0);
        // Out-of-range after lowering limit.
        drive(0, 1, 0, 1, 0, 0, 200, 150);
        drive(0, 0, 1, 1, 1, 1, 60, 0);
        drive(0, 1, 0, 1, 0, 0, 200, 150);
        drive(0, 0, 1, 0, 0, 1, 60, 0);
        // Reach 37 with tc and ovf set, then reset between edges.
        drive(0, 1, 0, 1, 1, 0, 37, 30);
        drive(0, 0, 1, 1, 1, 9, 37, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_data_out", 32'(data_out), 0);
        check("mid_rst_end_count", 32'(end_count), 1);
        check("mid_rst_tc", 32'(tc), 0);
        check("mid_rst_ovf", 32'(ovf), 0);
        m_cnt = 0; m_ovf = 1'b0;
        #1 rst = 1'b0;

        // Randomized traffic.
        cur_lim = 100;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0)
                cur_lim = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3))
                                                      : int'($urandom_range(0, 255));
            r = int'($urandom_range(0, 99));
            c = (r < 3);
            l = (r >= 3 && r < 13) || ($urandom_range(0, 39) == 0);
            e = ($urandom_range(0, 3) != 0);
            drive(c, l, e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)), cur_lim, int'($urandom_range(0, 255)));
        end

        wait_cyc = 0;
        while (sbq.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter N, default 8, count/limit/data width in bits (N >= 2).
REQ-002 Parameter STEP_W, default 4, step width in bits (1 <= STEP_W <= N).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 clr  input  1  synchronous clear of count and sticky flag.
REQ-006 load  input  1  synchronous load of data_in.
REQ-007 en  input  1  count enable.
REQ-008 up_down  input  1  1 = up, 0 = down.
REQ-009 sat  input  1  1 = saturate at bounds, 0 = wrap modulo (limit+1).
REQ-010 step  input  STEP_W  increment/decrement magnitude per enabled cycle.
REQ-011 limit  input  N  inclusive upper bound; legal count range 0..limit.
REQ-012 data_in  input  N  load value.
REQ-013 data_out  output  N  current count (registered).
REQ-014 end_count  output  1  combinational, 1 while data_out == 0.
REQ-015 at_limit  output  1  combinational, 1 while data_out == limit.
REQ-016 tc  output  1  registered one-cycle terminal pulse per bound event.
REQ-017 ovf  output  1  registered sticky flag, set by any bound event.

Function
REQ-018 Priority per edge SHALL be: clr > load > en > hold.
REQ-019 clr: count <= 0, ovf <= 0, tc <= 0.
REQ-020 load: count <= min(data_in, limit); ovf <= 0; tc <= 0.
REQ-021 en with step == 0 SHALL hold count and SHALL NOT raise tc or ovf.
REQ-022 All arithmetic SHALL use N+1-bit intermediates; step zero-extended to N.
REQ-023 Out-of-range state (count > limit, e.g. limit lowered) on en: count <= limit if sat else 0; bound event.
REQ-024 Up, sum = count + step: if sum <= limit, count <= sum, no event.
REQ-025 Up, sum > limit: sat=1 -> count <= limit; sat=0 -> count <= sum-(limit+1), or 0 if that result > limit; bound event.
REQ-026 Down: if step <= count, count <= count - step, no event.
REQ-027 Down, step > count: sat=1 -> count <= 0; sat=0 -> count <= count+limit+1-step, or limit if that is negative; bound event.
REQ-028 A bound event SHALL occur on every enabled cycle whose request crosses a bound, including when already at that bound.
REQ-029 Bound event: tc = 1 in the cycle after the edge (aligned with the new data_out); ovf <= 1.
REQ-030 tc SHALL be 0 in every cycle not immediately following a bound-event edge.
REQ-031 limit == 0: count stays 0; every enabled non-zero step is a bound event.
REQ-032 up_down, sat, step, limit SHALL be sampled only at the edge; changes mid-count take effect next enabled cycle.
REQ-033 Hold (no clr/load/en): count, ovf unchanged; tc = 0.

Reset
REQ-034 rst = 1 SHALL immediately force data_out = 0, tc = 0, ovf = 0, independent of clk.
REQ-035 During reset end_count = 1; at_limit = 1 only if limit == 0.
REQ-036 Reset asserted mid-operation SHALL abandon any pending update; first edge after release obeys REQ-018.

Verification
REQ-037 Count 37, rst pulsed between edges -> data_out 0, end_count 1, tc 0, ovf 0 before next edge.
REQ-038 N=8, limit=9, sat=0, step=3, load 8, en up 2 cycles -> data_out 1 with tc 1, ovf 1; then 4 with tc 0, ovf 1.
REQ-039 limit=200, sat=1, load 5, step=4, en down 3 cycles -> 1 (tc 0), 0 (tc 1), 0 (tc 1); end_count 1.
REQ-040 limit=50, load data_in=100 -> data_out 50, at_limit 1, ovf 0.
REQ-041 ovf=1, clr=load=en=1 same edge, data_in=7 -> data_out 0, ovf 0, tc 0.
REQ-042 Count 12, en=1, step=0, 5 cycles -> data_out stays 12, tc 0 throughout.
